// File: rtl/vthernet_pkg.sv
// Shared Ethernet/UDP receive constants and types.
// Holds the RX ring write-FSM encoding and slot metadata layout.
package vthernet_pkg;

  localparam int          OCT  = 8;
  localparam logic [7:0]  PRE  = 8'h55;
  localparam logic [7:0]  SFD  = 8'hD5;
  localparam logic [15:0] IPV4 = 16'h0800;

  localparam int RX_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    SKIP = 2'd2
  } wr_st_e;

  typedef struct packed {
    logic [RX_LEN_W-1:0] len;
    logic                trunc;
  } slot_meta_t;

endpackage

// File: rtl/rx_ring_ram.sv
// Simple dual-port byte RAM for the RX ring.
// One write port, one registered read port, same clock.
module rx_ring_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_udp_ring.sv
// Multi-slot UDP payload receive ring with per-slot length/trunc.
// Define RX_RING_STATS_EN to add drop_count/frame_count counters.
module rx_udp_ring
  import vthernet_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = OCT,
  parameter int CNT_W  = 16
) (
  input  logic                     RX_CLK,
  input  logic                     rst_n,
  input  logic                     wr_data_v,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_abort,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W:0]          rd_len,
  output logic                     rd_trunc,
  input  logic                     rd_release,
  output logic                     rd_valid,
  output logic [$clog2(SLOTS):0]   fill_count
`ifdef RX_RING_STATS_EN
  ,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         frame_count
`endif
);

  localparam int PTR_W  = $clog2(SLOTS);
  localparam int FILL_W = PTR_W + 1;
  localparam int RAM_AW = PTR_W + ADDR_W;

  wr_st_e            state_q, state_d;
  logic [ADDR_W:0]   offset_q, offset_d;
  logic              trunc_q, trunc_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  slot_meta_t        meta_q [SLOTS];
  slot_meta_t        head;

  logic              we;
  logic [RAM_AW-1:0] waddr;
  logic              commit;
  logic              rel;
  logic              full;
`ifdef RX_RING_STATS_EN
  logic              drop;
  logic [CNT_W-1:0]  drop_q, frame_q;
`endif

  assign full = (fill_q == FILL_W'(SLOTS));
  assign rel  = rd_release && (fill_q != '0);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    trunc_d  = trunc_q;
    we       = 1'b0;
    waddr    = '0;
    commit   = 1'b0;
`ifdef RX_RING_STATS_EN
    drop     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (wr_data_v) begin
          if (!full) begin
            we       = 1'b1;
            waddr    = {wr_ptr_q, {ADDR_W{1'b0}}};
            offset_d = (ADDR_W+1)'(1);
            trunc_d  = 1'b0;
            state_d  = RECV;
          end else begin
`ifdef RX_RING_STATS_EN
            drop     = 1'b1;
`endif
            state_d  = SKIP;
          end
        end
      end
      RECV: begin
        if (wr_abort) begin
          state_d = SKIP;
        end else if (wr_data_v) begin
          // offset MSB set means the slot is full: keep counting only as trunc
          if (!offset_q[ADDR_W]) begin
            we       = 1'b1;
            waddr    = {wr_ptr_q, offset_q[ADDR_W-1:0]};
            offset_d = offset_q + (ADDR_W+1)'(1);
          end else begin
            trunc_d  = 1'b1;
          end
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      SKIP: begin
        if (!wr_data_v) state_d = IDLE;
      end
      default: state_d = SKIP;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SKIP;
      offset_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      trunc_q  <= trunc_d;
    end
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < SLOTS; i++) meta_q[i] <= '0;
    end else begin
      if (commit) begin
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        meta_q[wr_ptr_q] <= '{len: RX_LEN_W'(offset_q), trunc: trunc_q};
      end
      if (rel) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (commit && !rel)      fill_q <= fill_q + FILL_W'(1);
      else if (!commit && rel) fill_q <= fill_q - FILL_W'(1);
    end
  end

`ifdef RX_RING_STATS_EN
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      if (drop && (drop_q != '1))    drop_q  <= drop_q + CNT_W'(1);
      if (commit && (frame_q != '1)) frame_q <= frame_q + CNT_W'(1);
    end
  end

  assign drop_count  = drop_q;
  assign frame_count = frame_q;
`endif

  assign head       = meta_q[rd_ptr_q];
  assign rd_valid   = (fill_q != '0);
  assign rd_len     = rd_valid ? (ADDR_W+1)'(head.len) : '0;
  assign rd_trunc   = rd_valid & head.trunc;
  assign fill_count = fill_q;

  rx_ring_ram #(
    .AW (RAM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk   (RX_CLK),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .raddr ({rd_ptr_q, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_rx_udp_ring.sv
// Scoreboard bench for rx_udp_ring (4 slots of 64 bytes).
// Stats ports are connected and checked when RX_RING_STATS_EN is defined.
module tb_rx_udp_ring;

  localparam int SLOTS  = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int SLOT_B = 2**ADDR_W;
  localparam int FW     = $clog2(SLOTS) + 1;

  logic              RX_CLK = 1'b0;
  logic              rst_n;
  logic              wr_data_v;
  logic [DATA_W-1:0] wr_data;
  logic              wr_abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   rd_len;
  logic              rd_trunc;
  logic              rd_release;
  logic              rd_valid;
  logic [FW-1:0]     fill_count;
`ifdef RX_RING_STATS_EN
  logic [CNT_W-1:0]  drop_count;
  logic [CNT_W-1:0]  frame_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int          exp_len  [$];
  bit          exp_tr   [$];
  logic [7:0]  exp_data [$];
  logic [7:0]  got      [$];
  int          m_drop   = 0;
  int          m_frames = 0;

  rx_udp_ring #(
    .SLOTS  (SLOTS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .RX_CLK      (RX_CLK),
    .rst_n       (rst_n),
    .wr_data_v   (wr_data_v),
    .wr_data     (wr_data),
    .wr_abort    (wr_abort),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_len      (rd_len),
    .rd_trunc    (rd_trunc),
    .rd_release  (rd_release),
    .rd_valid    (rd_valid),
    .fill_count  (fill_count)
`ifdef RX_RING_STATS_EN
    ,
    .drop_count  (drop_count),
    .frame_count (frame_count)
`endif
  );

  always #5 RX_CLK = ~RX_CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit hit, bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic model_pop_head();
    int n;
    n = exp_len.pop_front();
    void'(exp_tr.pop_front());
    repeat (n) void'(exp_data.pop_front());
  endtask

  task automatic send_frame(input int n, input int base,
                            input int abort_at, input bit rel_commit);
    int pre;
    int keep;
    pre = exp_len.size();
    for (int i = 0; i < n; i++) begin
      wr_data_v = 1'b1;
      wr_data   = 8'(base + i);
      wr_abort  = (i == abort_at);
      tick();
    end
    wr_data_v  = 1'b0;
    wr_abort   = 1'b0;
    rd_release = rel_commit;
    tick();
    rd_release = 1'b0;
    if (abort_at >= 0 && abort_at < n) begin
    end else if (pre == SLOTS) begin
      m_drop++;
    end else begin
      keep = (n > SLOT_B) ? SLOT_B : n;
      exp_len.push_back(keep);
      exp_tr.push_back(n > SLOT_B);
      for (int i = 0; i < keep; i++) exp_data.push_back(8'(base + i));
      m_frames++;
    end
    if (rel_commit && pre > 0) model_pop_head();
  endtask

  task automatic read_head(input int n);
    got.delete();
    for (int a = 0; a < n; a++) begin
      rd_addr = ADDR_W'(a);
      tick();
      got.push_back(rd_data);
    end
  endtask

  task automatic test_drain_head(input string tag);
    int         n;
    bit         tr;
    int         bad;
    int         bad_i;
    logic [7:0] e;
    logic [7:0] bad_g;
    logic [7:0] bad_e;
    tests_run++;
    if (exp_len.size() == 0) begin
      if (rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s empty_valid: got %b want 0", tag, rd_valid);
      end
      return;
    end
    n  = exp_len.pop_front();
    tr = exp_tr.pop_front();
    if (rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s rd_valid: got %b want 1", tag, rd_valid);
    end
    tests_run++;
    if (rd_len !== (ADDR_W+1)'(n)) begin
      tests_failed++;
      $display("FAIL %s rd_len: got %0d want %0d", tag, rd_len, n);
    end
    tests_run++;
    if (rd_trunc !== tr) begin
      tests_failed++;
      $display("FAIL %s rd_trunc: got %b want %b", tag, rd_trunc, tr);
    end
    read_head(n);
    bad   = 0;
    bad_i = 0;
    bad_g = '0;
    bad_e = '0;
    for (int i = 0; i < n; i++) begin
      e = exp_data.pop_front();
      if (got[i] !== e) begin
        if (bad == 0) begin
          bad_i = i;
          bad_g = got[i];
          bad_e = e;
        end
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s rd_data: %0d bad, first at %0d got %h want %h",
               tag, bad, bad_i, bad_g, bad_e);
    end
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    tests_run++;
    if (fill_count !== FW'(exp_len.size())) begin
      tests_failed++;
      $display("FAIL %s fill_after_release: got %0d want %0d",
               tag, fill_count, exp_len.size());
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    wr_data_v  = 1'b0;
    wr_data    = '0;
    wr_abort   = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({rd_data, rd_len, rd_trunc, rd_valid, fill_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h len=%0d tr=%b v=%b fill=%0d want 0",
               rd_data, rd_len, rd_trunc, rd_valid, fill_count);
    end
`ifdef RX_RING_STATS_EN
    tests_run++;
    if (drop_count !== '0 || frame_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_counters: got drop=%0d frames=%0d want 0",
               drop_count, frame_count);
    end
`endif
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single();
    send_frame(64, 0, -1, 1'b0);
    tests_run++;
    if (fill_count !== FW'(1)) begin
      tests_failed++;
      $display("FAIL single_fill: got %0d want 1", fill_count);
    end
    test_drain_head("single");
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_valid_after: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 5; k++) send_frame(10 * k, 16 * k + 8'h40, -1, 1'b0);
    tests_run++;
    if (fill_count !== FW'(exp_len.size())) begin
      tests_failed++;
      $display("FAIL full_fill: got %0d want %0d", fill_count, exp_len.size());
    end
`ifdef RX_RING_STATS_EN
    tests_run++;
    if (drop_count !== CNT_W'(m_drop)) begin
      tests_failed++;
      $display("FAIL full_drop: got %0d want %0d", drop_count, m_drop);
    end
`endif
    for (int k = 0; k < SLOTS; k++) test_drain_head($sformatf("full%0d", k));
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    tests_run++;
    if (fill_count !== '0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_release: got fill=%0d v=%b want 0/0", fill_count, rd_valid);
    end
  endtask

  task automatic test_trunc();
    send_frame(70, 8'h80, -1, 1'b0);
    send_frame(5, 8'hC0, -1, 1'b0);
    test_drain_head("trunc_long");
    test_drain_head("trunc_next");
  endtask

  task automatic test_abort();
    send_frame(30, 8'h11, 12, 1'b0);
    tests_run++;
    if (fill_count !== FW'(exp_len.size())) begin
      tests_failed++;
      $display("FAIL abort_fill: got %0d want %0d", fill_count, exp_len.size());
    end
`ifdef RX_RING_STATS_EN
    tests_run++;
    if (frame_count !== CNT_W'(m_frames)) begin
      tests_failed++;
      $display("FAIL abort_frames: got %0d want %0d", frame_count, m_frames);
    end
`endif
    send_frame(15, 8'h90, -1, 1'b0);
    test_drain_head("after_abort");
  endtask

  task automatic test_back_to_back();
    send_frame(7, 8'h20, -1, 1'b0);
    send_frame(11, 8'h30, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send_frame(3 + 5 * k, 8'hA0 + 8 * k, -1, 1'b1);
      tests_run++;
      if (fill_count !== FW'(2)) begin
        tests_failed++;
        $display("FAIL simul_fill%0d: got %0d want 2", k, fill_count);
      end
    end
    test_drain_head("simul_a");
    test_drain_head("simul_b");
  endtask

  task automatic test_reset_mid();
    send_frame(9, 8'h55, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      wr_data_v = 1'b1;
      wr_data   = 8'(8'hE0 + i);
      if (i == 7) begin
        rst_n = 1'b0;
        #1;
        exp_len.delete();
        exp_tr.delete();
        exp_data.delete();
        m_drop   = 0;
        m_frames = 0;
        tests_run++;
        if ({rd_data, rd_len, rd_trunc, rd_valid, fill_count} !== '0) begin
          tests_failed++;
          $display("FAIL midreset_outputs: got data=%h len=%0d tr=%b v=%b fill=%0d want 0",
                   rd_data, rd_len, rd_trunc, rd_valid, fill_count);
        end
`ifdef RX_RING_STATS_EN
        tests_run++;
        if (drop_count !== '0 || frame_count !== '0) begin
          tests_failed++;
          $display("FAIL midreset_counters: got drop=%0d frames=%0d want 0",
                   drop_count, frame_count);
        end
`endif
      end
      if (i == 9) rst_n = 1'b1;
      tick();
    end
    wr_data_v = 1'b0;
    tick();
    tests_run++;
    if (fill_count !== '0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_ignored: got fill=%0d v=%b want 0/0", fill_count, rd_valid);
    end
    send_frame(13, 8'h71, -1, 1'b0);
    test_drain_head("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_trunc();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_udp_ring.md
Name: rx_udp_ring

Overview:
- Parametrised multi-slot receive buffer for UDP payload.
- Successor to the single-frame RX memory currently in the top level.
- Accepts the byte stream emitted by the UDP receiver and stores each datagram in its own slot of a SLOTS-deep ring. The CPU-side logic can then drain frames in order while new frames arrive.
- Adds per-slot length, truncation flag, full-ring drop and frame abort, none of which the single buffer has.

Parameters:
- SLOTS, 4, number of frame slots; power of two, 2..16.
- ADDR_W, 11, byte-address width inside a slot; slot size is 2**ADDR_W bytes.
- DATA_W, 8, stream byte width (OCT).
- CNT_W, 16, width of statistics counters.

Ports:
- RX_CLK  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_data_v  in  1  payload byte valid; one contiguous high run = one frame.
- wr_data  in  DATA_W  payload byte.
- wr_abort  in  1  discard the frame currently being written.
- rd_addr  in  ADDR_W  byte offset within the head slot.
- rd_data  out  DATA_W  head-slot byte at rd_addr, registered.
- rd_len  out  ADDR_W+1  byte count of head frame.
- rd_trunc  out  1  head frame was truncated.
- rd_release  in  1  pulse: free the head slot.
- rd_valid  out  1  at least one committed frame present; doubles as irq level.
- fill_count  out  log2(SLOTS)+1  committed frames held.
- drop_count  out  CNT_W  frames dropped because the ring was full (RX_RING_STATS_EN only).
- frame_count  out  CNT_W  frames committed (RX_RING_STATS_EN only).

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=rd_ptr=0, fill_count=0, offset=0.
  - rd_data=0, rd_valid=0, rd_len=0, rd_trunc=0, counters=0.
  - Write FSM=SKIP.
  - RAM contents undefined.
- Write FSM states: IDLE, RECV, SKIP.
- IDLE:
  - wr_data_v=1 and fill_count<SLOTS: write byte at {wr_ptr,0}, offset<=1, go to RECV.
  - wr_data_v=1 and ring full: drop_count+1 (saturating), go to SKIP.
- RECV, wr_data_v=1:
  - If offset < 2**ADDR_W, write byte at {wr_ptr,offset} and increment offset.
  - Otherwise discard the byte and set trunc flag.
  - offset saturates at 2**ADDR_W.
- RECV, wr_data_v=0 (commit):
  - len[wr_ptr]<=offset, trunc[wr_ptr]<=flag.
  - wr_ptr+1 (mod SLOTS), fill_count+1, frame_count+1 (saturating).
  - Go to IDLE.
- wr_abort=1 in RECV (including the commit cycle): no commit, wr_ptr unchanged, go to SKIP. Aborted frames are not counted.
- wr_abort in IDLE or SKIP: ignored.
- SKIP: wait for wr_data_v=0, then go to IDLE. Because reset enters SKIP, a frame already in flight at reset release is dropped silently.
- Full check happens only at frame start. Slots freed during RECV do not rescue a frame already going to SKIP.
- Read path:
  - rd_data <= mem[{rd_ptr,rd_addr}] each cycle: 1-cycle latency, always enabled.
  - Data at rd_addr >= rd_len is undefined.
  - rd_len and rd_trunc are combinational from head metadata, forced to 0 when fill_count=0.
  - rd_valid = (fill_count!=0).
- rd_release with fill_count>0: rd_ptr+1 and fill_count-1.
- rd_release with fill_count=0: ignored.
- Commit and release in the same cycle: both pointers advance, fill_count unchanged.
- Minimum frame is 1 byte; a 0-byte frame cannot occur.

Optional Feature:
- Macro RX_RING_STATS_EN.
- Defined: drop_count and frame_count ports and registers exist as above, CNT_W wide, saturating, cleared only by reset.
- Undefined: both ports and counters are absent. Drop and commit behaviour is otherwise identical.

Decomposition:
- Shared package vthernet_pkg holds:
  - OCT, PRE, SFD and IPV4 constants.
  - The write-FSM state encoding (IDLE/RECV/SKIP).
  - A slot-metadata struct {len, trunc}.
- One sub-module is natural: rx_ring_ram, a simple dual-port RAM.
  - Depth SLOTS*2**ADDR_W.
  - One write port and one registered read port on RX_CLK.
  - Keeps the RAM inferable on FPGA targets.
- Metadata lives in flops inside rx_udp_ring.

Test Plan:
- Single frame: 64-byte stream 0x00..0x3F, rd_addr 0..63 → rd_valid=1, rd_len=64, rd_trunc=0, rd_data matches one cycle after each addr; rd_release → rd_valid=0, fill_count=0.
- Fill to full (SLOTS=4): 5 frames of 10, 20, 30, 40, 50 bytes, no release → fill_count=4, drop_count=1. Releases then return lengths 10, 20, 30, 40 in order.
- Truncation (ADDR_W=4): 20-byte frame → rd_len=16, rd_trunc=1, bytes 0..15 intact; next 5-byte frame → rd_len=5, rd_trunc=0.
- Abort: 30-byte frame with wr_abort asserted at byte 12 → fill_count unchanged, frame_count unchanged; next frame lands in the same slot.
- Simultaneous: fill_count=2, rd_release in the exact commit cycle of a third frame → fill_count stays 2, rd_ptr and wr_ptr both advance, wrap correct after 8 frames.
- Reset mid-frame: deassert rst_n while wr_data_v=1 at byte 7 → all outputs 0, remainder of frame ignored, next frame stored at slot 0 with correct length.
